// File: rtl/reg_bus_master.sv
// ---------------------------------------------------------------------------
// reg_bus_master
//
// Turns single commands (write, read, poll) into strobes on a simple
// register bus and returns a one-cycle completion pulse for each command.
//
// Parameters
//   RD_LAT    cycles from a master_rd cycle to the cycle in which
//             master_rddata is valid (1..4)
//   POLL_MAX  maximum read attempts per poll command (1..255)
//
// Build option
//   REG_BUS_MASTER_POLL_EN  defined: op 10 is a poll (repeated masked
//                           compare).  Undefined: op 10 is treated as an
//                           illegal op and the poll counter/compare logic
//                           is not built.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_op              00 write, 01 read, 10 poll, 11 illegal
//   cmd_addr/data/mask  target address, write data or expected value, mask
//   rsp_valid           one-cycle completion pulse
//   rsp_data/rsp_err    read data (0 for write/illegal); timeout/illegal flag
//   master_addr/wr/rd   register bus address and strobes
//   master_wrdata       register bus write data
//   master_rddata       register bus read data (registered by the responder)
//   busy                high whenever the master is not idle
// ---------------------------------------------------------------------------
module reg_bus_master #(
    parameter int RD_LAT   = 1,
    parameter int POLL_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [3:0]  master_addr,
    output logic        master_wr,
    output logic        master_rd,
    output logic [31:0] master_wrdata,
    input  logic [31:0] master_rddata,
    output logic        busy
);

    // One-hot so that every status output is a plain flop bit.
    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_WR   = 5'b00010;
    localparam logic [4:0] ST_RD   = 5'b00100;
    localparam logic [4:0] ST_WAIT = 5'b01000;
    localparam logic [4:0] ST_RESP = 5'b10000;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;

    localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

    logic [4:0]  state_r;
    logic [4:0]  state_s;
    logic [2:0]  wait_cnt_r;
    logic [3:0]  addr_r;
    logic [31:0] wrdata_r;
    logic [31:0] rsp_data_r;
    logic        rsp_err_r;
    logic        accept_s;
    logic        wait_done_s;
    logic        poll_retry_s;
    logic        poll_fail_s;

    assign accept_s    = state_r[0] & cmd_valid;
    assign wait_done_s = (state_r == ST_WAIT) && (wait_cnt_r == WAIT_LAST);

`ifdef REG_BUS_MASTER_POLL_EN
    localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

    logic        poll_r;
    logic [31:0] mask_r;
    logic [7:0]  attempt_r;
    logic        poll_match_s;

    // Poll command context; attempt_r counts the master_rd pulses issued so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_r    <= 1'b0;
            mask_r    <= 32'h0;
            attempt_r <= 8'd0;
        end else if (accept_s) begin
            poll_r    <= (cmd_op == OP_POLL);
            mask_r    <= cmd_mask;
            attempt_r <= 8'd0;
        end else if (state_r == ST_RD) begin
            attempt_r <= attempt_r + 8'd1;
        end else begin
            attempt_r <= attempt_r;
        end
    end

    // Masked compare of the sample against the expected value held in wrdata_r.
    always_comb begin
        poll_match_s = ((master_rddata & mask_r) == (wrdata_r & mask_r));
        if (poll_r && !poll_match_s) begin
            if (attempt_r < POLL_LIMIT) begin
                poll_retry_s = 1'b1;
                poll_fail_s  = 1'b0;
            end else begin
                poll_retry_s = 1'b0;
                poll_fail_s  = 1'b1;
            end
        end else begin
            poll_retry_s = 1'b0;
            poll_fail_s  = 1'b0;
        end
    end
`else
    logic unused_poll_s;

    assign poll_retry_s  = 1'b0;
    assign poll_fail_s   = 1'b0;
    assign unused_poll_s = ^{cmd_mask, 8'(POLL_MAX)};
`endif

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WR:   state_s = ST_WR;
                        OP_RD:   state_s = ST_RD;
`ifdef REG_BUS_MASTER_POLL_EN
                        OP_POLL: state_s = ST_RD;
`endif
                        default: state_s = ST_RESP;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR:   state_s = ST_RESP;
            ST_RD:   state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_done_s) begin
                    if (poll_retry_s) begin
                        state_s = ST_RD;
                    end else begin
                        state_s = ST_RESP;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Read latency counter; restarts whenever the master is not waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= 3'd0;
        end else if ((state_r == ST_WAIT) && !wait_done_s) begin
            wait_cnt_r <= wait_cnt_r + 3'd1;
        end else begin
            wait_cnt_r <= 3'd0;
        end
    end

    // Command fields captured on accept and held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r   <= 4'd0;
            wrdata_r <= 32'h0;
        end else if (accept_s) begin
            addr_r   <= cmd_addr;
            wrdata_r <= cmd_data;
        end else begin
            addr_r   <= addr_r;
            wrdata_r <= wrdata_r;
        end
    end

    // Response payload: cleared on accept (illegal flagged immediately),
    // loaded with the final sample when the last read wait ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_r <= 32'h0;
            rsp_err_r  <= 1'b0;
        end else if (accept_s) begin
            rsp_data_r <= 32'h0;
            rsp_err_r  <= (state_s == ST_RESP);
        end else if (wait_done_s && !poll_retry_s) begin
            rsp_data_r <= master_rddata;
            rsp_err_r  <= poll_fail_s;
        end else begin
            rsp_data_r <= rsp_data_r;
            rsp_err_r  <= rsp_err_r;
        end
    end

    assign cmd_ready     = state_r[0];
    assign busy          = ~state_r[0];
    assign master_wr     = state_r[1];
    assign master_rd     = state_r[2];
    assign rsp_valid     = state_r[4];
    assign rsp_data      = rsp_data_r;
    assign rsp_err       = rsp_err_r;
    assign master_addr   = addr_r;
    assign master_wrdata = wrdata_r;

endmodule

// File: tb/tb_reg_bus_master.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_master
//
// Directed and randomized commands against reg_bus_master (RD_LAT=1,
// POLL_MAX=4) with a register-slave responder.  Expected latency, response
// data/error and strobe counts come from a per-command reference model over
// an array copy of the register file.  Poll expectations follow
// REG_BUS_MASTER_POLL_EN (op 10 is illegal when it is undefined).
// ---------------------------------------------------------------------------
module tb_reg_bus_master;

    localparam int RD_LAT   = 1;
    localparam int POLL_MAX = 4;
    localparam int BUDGET   = 200;
`ifdef REG_BUS_MASTER_POLL_EN
    localparam bit POLL_ON = 1'b1;
`else
    localparam bit POLL_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  master_addr;
    logic        master_wr;
    logic        master_rd;
    logic [31:0] master_wrdata;
    logic [31:0] master_rddata;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] slave_regs [16];
    logic [31:0] slave_rddata;
    int          slave_rd_cnt = 0;
    int          slave_wr_cnt = 0;
    int          slave_set_on = 0;
    logic [31:0] model_regs [16];

    reg_bus_master #(.RD_LAT(RD_LAT), .POLL_MAX(POLL_MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .cmd_mask      (cmd_mask),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .master_addr   (master_addr),
        .master_wr     (master_wr),
        .master_rd     (master_rd),
        .master_wrdata (master_wrdata),
        .master_rddata (master_rddata),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register slave with one cycle of read latency; bit0 of register 0 can be
    // forced on from a chosen absolute read number onward.
    always @(posedge clk) begin
        if (master_wr) begin
            slave_regs[master_addr] <= master_wrdata;
            slave_wr_cnt <= slave_wr_cnt + 1;
        end
        if (master_rd) begin
            slave_rd_cnt <= slave_rd_cnt + 1;
            if (master_addr == 4'd0 && slave_set_on != 0 && slave_rd_cnt + 1 >= slave_set_on)
                slave_rddata <= slave_regs[0] | 32'h1;
            else
                slave_rddata <= slave_regs[master_addr];
        end
    end
    assign master_rddata = slave_rddata;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ctrl"}, 32'({cmd_ready, busy, rsp_valid, rsp_err, master_wr, master_rd}), 32'h20);
        check({tag, ".rsp_data"}, rsp_data, 32'h0);
        check({tag, ".bus"}, {28'h0, master_addr} | master_wrdata, 32'h0);
    endtask

    // Issue one command, follow it to completion and compare with the model.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [3:0] addr,
                          input logic [31:0] data, input logic [31:0] mask, input int set_on);
        int exp_lat, exp_wr, exp_rd, n;
        int wr0, rd0, lat, first_wr, first_rd, stray, hold_bad, both;
        logic [31:0] exp_data, v, got_data;
        logic exp_err, hit, got_err;

        exp_wr = 0; exp_rd = 0; exp_data = 32'h0; exp_err = 1'b0; exp_lat = 1;
        if (op == 2'b00) begin
            exp_lat = 2; exp_wr = 1;
        end else if (op == 2'b01) begin
            exp_lat = 2 + RD_LAT; exp_rd = 1; exp_data = model_regs[addr];
        end else if (op == 2'b10 && POLL_ON) begin
            hit = 1'b0; n = 0; v = 32'h0;
            while (!hit && n < POLL_MAX) begin
                n++;
                v = model_regs[addr];
                if (addr == 4'd0 && set_on != 0 && n >= set_on) v = v | 32'h1;
                hit = (((v ^ data) & mask) == 32'h0);
            end
            exp_rd = n; exp_data = v; exp_err = !hit; exp_lat = n * (1 + RD_LAT) + 1;
        end else begin
            exp_lat = 1; exp_err = 1'b1;
        end

        wr0 = slave_wr_cnt;
        rd0 = slave_rd_cnt;
        slave_set_on = (set_on != 0) ? rd0 + set_on : 0;
        check({tag, ".ready"}, 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
        @(posedge clk); #1;
        lat = 0; first_wr = 0; first_rd = 0; stray = 0; hold_bad = 0; both = 0;
        got_data = 32'hx; got_err = 1'bx;
        for (int k = 1; k <= BUDGET && lat == 0; k++) begin
            if (master_wr && master_rd) both++;
            if (master_wr === 1'b1 && first_wr == 0) first_wr = k;
            if (master_rd === 1'b1 && first_rd == 0) first_rd = k;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) stray++;
            if (master_addr !== addr || master_wrdata !== data) hold_bad++;
            if (rsp_valid === 1'b1) begin
                lat = k; got_data = rsp_data; got_err = rsp_err; cmd_valid = 1'b0;
            end else begin
                // Noise on the command port while busy must be ignored.
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom);
                cmd_addr  = 4'($urandom);
                cmd_data  = $urandom;
                cmd_mask  = $urandom;
                @(posedge clk); #1;
            end
        end
        cmd_valid = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rsp_data"}, got_data, exp_data);
        check({tag, ".rsp_err"}, 32'(got_err), 32'(exp_err));
        check({tag, ".wr_pulses"}, 32'(slave_wr_cnt - wr0), 32'(exp_wr));
        check({tag, ".rd_pulses"}, 32'(slave_rd_cnt - rd0), 32'(exp_rd));
        check({tag, ".first_wr"}, 32'(first_wr), (exp_wr != 0) ? 32'd1 : 32'd0);
        check({tag, ".first_rd"}, 32'(first_rd), (exp_rd != 0) ? 32'd1 : 32'd0);
        check({tag, ".wr_and_rd"}, 32'(both), 32'd0);
        check({tag, ".busy_ready"}, 32'(stray), 32'd0);
        check({tag, ".bus_hold"}, 32'(hold_bad), 32'd0);
        @(posedge clk); #1;
        check({tag, ".idle"}, 32'({rsp_valid, cmd_ready, busy}), 32'h2);
        if (op == 2'b00) model_regs[addr] = data;
        slave_set_on = 0;
    endtask

    initial begin
        int n;
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [31:0] data, mask;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 4'd0;
        cmd_data = 32'h0; cmd_mask = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        do_cmd("wr_addr1", 2'b00, 4'd1, 32'h20, $urandom, 0);
        do_cmd("rd_addr1", 2'b01, 4'd1, $urandom, $urandom, 0);
        do_cmd("wr_addr0", 2'b00, 4'd0, $urandom & 32'hFFFF_FFFE, $urandom, 0);
        do_cmd("poll_3rd", 2'b10, 4'd0, 32'h1, 32'h1, 3);
        do_cmd("poll_timeout", 2'b10, 4'd1, 32'h1, 32'h1, 0);

        // Reset while a read waits for data: abort with no response.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_wait_async");
        @(posedge clk); #1;
        check_reset_outputs("rst_wait_edge");
        rst = 1'b0;
        n = 0;
        repeat (4) begin
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) n++;
            @(posedge clk); #1;
        end
        check("rst_no_rsp", 32'(n), 32'd0);
        do_cmd("wr_after_rst", 2'b00, 4'd2, $urandom, $urandom, 0);

        do_cmd("op10", 2'b10, 4'd0, $urandom, $urandom, 0);
        do_cmd("op11", 2'b11, 4'($urandom), $urandom, $urandom, 0);

        for (int a = 0; a < 16; a++) do_cmd("init", 2'b00, 4'(a), $urandom, $urandom, 0);

        for (int i = 0; i < 60; i++) begin
            op   = 2'($urandom_range(0, 3));
            addr = 4'($urandom);
            mask = $urandom;
            data = $urandom;
            if (op == 2'b10 && $urandom_range(0, 1) == 1)
                data = (model_regs[addr] & mask) | ($urandom & ~mask);
            do_cmd("rand", op, addr, data, mask, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
